// File: rtl/debug_response_tx_if.sv
// Interface for the debug response transmitter.
// It carries the capture strobe and data word, the UART byte handshake, and the status flags.
// The slave modport is used by debug_response_tx.
// The master modport is the view from the sequencer and UART side.
interface debug_response_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  DEBUG_LD_DATA_EN;
  logic [DATA_WIDTH-1:0] DEBUG_DATA;
  logic                  TX_READY;
  logic                  TX_LOAD;
  logic [7:0]            TX_BYTE;
  logic                  DEBUG_TX_BUSY;
  logic                  DEBUG_TX_OVERRUN;
  logic                  OVERRUN_CLR;

  modport slave (
    input  DEBUG_LD_DATA_EN, DEBUG_DATA, TX_READY, OVERRUN_CLR,
    output TX_LOAD, TX_BYTE, DEBUG_TX_BUSY, DEBUG_TX_OVERRUN
  );

  modport master (
    output DEBUG_LD_DATA_EN, DEBUG_DATA, TX_READY, OVERRUN_CLR,
    input  TX_LOAD, TX_BYTE, DEBUG_TX_BUSY, DEBUG_TX_OVERRUN
  );
endinterface

// File: rtl/debug_response_tx.sv
// debug_response_tx: frames a captured debug word as HEADER followed by its data bytes.
// The data bytes are sent most significant byte first, one byte per UART TX handshake.
// It holds one active frame and one pending word, and keeps a sticky overrun flag.
// Optional macro DEBUG_TX_CHECKSUM_EN appends a checksum byte so that the frame sums to zero.
module debug_response_tx #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic              CLK,
  input  logic              RESETN,
  debug_response_tx_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int LAST = NB + 1;
`else
  localparam int LAST = NB;
`endif
  localparam int IDX_W = $clog2(LAST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wait_first_q, wait_first_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  tx_load_q, tx_load_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic [7:0]            cur_byte;
  logic                  frame_done;
  logic                  overrun_set;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [7:0]            acc_q, acc_d;
`endif

  // Byte for the current index: the header, then the top byte of the shift register, then optionally the checksum
  always_comb begin
    cur_byte = shift_q[DATA_WIDTH-1 -: 8];
    if (idx_q == '0) cur_byte = HEADER;
`ifdef DEBUG_TX_CHECKSUM_EN
    else if (idx_q == LAST_IDX) cur_byte = 8'h00 - acc_q;
`endif
  end

  // Next-state logic: the frame sequencer, pending-slot management and overrun detection
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_first_d = wait_first_q;
    pend_vld_d   = pend_vld_q;
    tx_load_d    = 1'b0;
    tx_byte_d    = tx_byte_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    frame_done   = 1'b0;
    overrun_set  = 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
    acc_d        = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.DEBUG_LD_DATA_EN) begin
          shift_d = bus.DEBUG_DATA;
          idx_d   = '0;
          state_d = S_SEND;
`ifdef DEBUG_TX_CHECKSUM_EN
          acc_d   = 8'h00;
`endif
        end
      end
      S_SEND: begin
        if (bus.TX_READY) begin
          tx_load_d    = 1'b1;
          tx_byte_d    = cur_byte;
          state_d      = S_WAIT;
          wait_first_d = 1'b1;
          if (idx_q != '0) shift_d = shift_q << 8;
`ifdef DEBUG_TX_CHECKSUM_EN
          acc_d        = acc_q + cur_byte;
`endif
        end
      end
      S_WAIT: begin
        // The UART keeps TX_READY high for one cycle after a load, so that cycle is skipped
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (bus.TX_READY) begin
          if (idx_q == LAST_IDX) begin
            frame_done = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
      if (pend_vld_q) begin
        shift_d    = pend_q;
        pend_vld_d = 1'b0;
        idx_d      = '0;
        state_d    = S_SEND;
`ifdef DEBUG_TX_CHECKSUM_EN
        acc_d      = 8'h00;
`endif
      end else begin
        state_d = S_IDLE;
      end
    end

    // A strobe in the completion cycle with no pending word starts the next frame directly
    if (bus.DEBUG_LD_DATA_EN && (state_q != S_IDLE)) begin
      if (pend_vld_q) begin
        overrun_set = 1'b1;
      end else if (frame_done) begin
        shift_d = bus.DEBUG_DATA;
        idx_d   = '0;
        state_d = S_SEND;
`ifdef DEBUG_TX_CHECKSUM_EN
        acc_d   = 8'h00;
`endif
      end else begin
        pend_d     = bus.DEBUG_DATA;
        pend_vld_d = 1'b1;
      end
    end

    overrun_d = overrun_set | (overrun_q & ~bus.OVERRUN_CLR);
  end

  // Control and output registers, cleared by the asynchronous reset
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wait_first_q <= 1'b0;
      pend_vld_q   <= 1'b0;
      tx_load_q    <= 1'b0;
      tx_byte_q    <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_first_q <= wait_first_d;
      pend_vld_q   <= pend_vld_d;
      tx_load_q    <= tx_load_d;
      tx_byte_q    <= tx_byte_d;
      overrun_q    <= overrun_d;
    end
  end

  // Data holding registers; they are only read while a matching valid state is set, so they need no reset
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
    pend_q  <= pend_d;
`ifdef DEBUG_TX_CHECKSUM_EN
    acc_q   <= acc_d;
`endif
  end

  assign bus.TX_LOAD          = tx_load_q;
  assign bus.TX_BYTE          = tx_byte_q;
  assign bus.DEBUG_TX_BUSY    = (state_q != S_IDLE) | pend_vld_q;
  assign bus.DEBUG_TX_OVERRUN = overrun_q;
endmodule
